// File: rtl/shift_pkg.sv
// Shared definitions for the parameterised shift register: the shift-mode
// encoding seen on the mode port and the controller state encoding.
package shift_pkg;

    // Values of the 2-bit mode port.
    typedef enum logic [1:0] {
        SH_LSR = 2'b00,   // logical right, collects shifted-out ones in sticky
        SH_LSL = 2'b01,   // logical left
        SH_ROR = 2'b10,   // rotate right
        SH_ROL = 2'b11    // rotate left
    } shift_mode_e;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Convert a raw 2-bit mode code into the enumerated type.
    function automatic shift_mode_e to_mode(input logic [1:0] code);
        return shift_mode_e'(code);
    endfunction

endpackage : shift_pkg

// File: rtl/shift_step.sv
// One-bit shift step: given the current register value, sticky flag and
// mode, produce the value after a single step. Purely combinational.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] d_i,
    input  logic             sticky_i,
    input  shift_mode_e      mode_i,
    output logic [WIDTH-1:0] d_o,
    output logic             sticky_o
);

    // Select the one-step result for the requested mode; only logical right
    // touches sticky, every other mode passes it through.
    always_comb begin
        d_o      = d_i;
        sticky_o = sticky_i;
        unique case (mode_i)
            SH_LSR: begin
                d_o      = {1'b0, d_i[WIDTH-1:1]};
                sticky_o = sticky_i | d_i[0];
            end
            SH_LSL: begin
                d_o = {d_i[WIDTH-2:0], 1'b0};
            end
            SH_ROR: begin
                d_o = {d_i[0], d_i[WIDTH-1:1]};
            end
            SH_ROL: begin
                d_o = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
            end
            default: begin
                d_o      = d_i;
                sticky_o = sticky_i;
            end
        endcase
    end

endmodule : shift_step

// File: rtl/shift_reg_param.sv
// Parameterised shift register with parallel load and a multi-cycle shift
// engine. A start request latches mode and amount, then one bit is moved
// per clock until the step counter runs out, followed by a one-cycle done.
//
// state | meaning
// IDLE  | accept load (priority) or start; otherwise hold data and sticky
// SHIFT | one step per edge, cnt counts down, last step at cnt==1
// DONE  | one-cycle completion pulse, then back to IDLE
module shift_reg_param
    import shift_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-2:0] data_in,
    input  logic             F,
    input  logic             load,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] data_out,
    output logic             sticky,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic               sticky_q, sticky_d;
    shift_mode_e        mode_q,  mode_d;

    logic [WIDTH-1:0]   step_data;
    logic               step_sticky;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d_i      (data_q),
        .sticky_i (sticky_q),
        .mode_i   (mode_q),
        .d_o      (step_data),
        .sticky_o (step_sticky)
    );

    // State, counter and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            sticky_q <= 1'b0;
            mode_q   <= SH_LSR;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            sticky_q <= sticky_d;
            mode_q   <= mode_d;
        end
    end

    // Next-state and datapath selection; requests are only honoured in IDLE,
    // and load takes priority over start.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        sticky_d = sticky_q;
        mode_d   = mode_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    data_d   = {F, data_in};
                    sticky_d = 1'b0;
                end else if (start) begin
                    mode_d = to_mode(mode);
                    cnt_d  = amount;
                    if (amount == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_d   = step_data;
                sticky_d = step_sticky;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out = data_q;
    assign sticky   = sticky_q;
    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);

endmodule : shift_reg_param

// File: tb/tb_shift_reg_param.sv
// Self-checking bench for shift_reg_param at WIDTH=24. Expected results are
// computed by a bit-serial reference model when each operation is issued,
// queued, and compared when the DUT raises done.
module tb_shift_reg_param;

    localparam int WIDTH = 24;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             clear_n;
    logic [WIDTH-2:0] data_in;
    logic             F;
    logic             load;
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] data_out;
    logic             sticky;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             sticky;
        int               lat;
    } sb_item_t;

    sb_item_t sb[$];

    logic [WIDTH-1:0] m_data;
    logic             m_sticky;

    shift_reg_param #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .data_in  (data_in),
        .F        (F),
        .load     (load),
        .start    (start),
        .mode     (mode),
        .amount   (amount),
        .data_out (data_out),
        .sticky   (sticky),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: apply amt single-bit steps of the given mode.
    task automatic model_op(input logic [1:0] md, input int amt);
        for (int i = 0; i < amt; i++) begin
            case (md)
                2'b00: begin
                    m_sticky = m_sticky | m_data[0];
                    m_data   = m_data >> 1;
                end
                2'b01: m_data = m_data << 1;
                2'b10: m_data = {m_data[0], m_data[WIDTH-1:1]};
                default: m_data = {m_data[WIDTH-2:0], m_data[WIDTH-1]};
            endcase
        end
    endtask

    task automatic do_load(input logic f, input logic [WIDTH-2:0] d);
        @(negedge clk);
        load    = 1'b1;
        F       = f;
        data_in = d;
        @(negedge clk);
        load     = 1'b0;
        m_data   = {f, d};
        m_sticky = 1'b0;
        chk("load_data", 32'(data_out), 32'(m_data));
        chk("load_sticky", 32'(sticky), 32'(m_sticky));
    endtask

    // Issue a shift, then watch for done within a cycle budget. With poke set,
    // start is held high and mode/amount are scrambled while the shift runs.
    task automatic do_op(input logic [1:0] md, input logic [CNT_W-1:0] amt, input bit poke);
        sb_item_t it;
        sb_item_t got;
        int       n;
        int       busy_cnt;
        bit       seen;
        model_op(md, int'(amt));
        it.data   = m_data;
        it.sticky = m_sticky;
        it.lat    = int'(amt);
        sb.push_back(it);
        @(negedge clk);
        start  = 1'b1;
        mode   = md;
        amount = amt;
        @(negedge clk);
        n        = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && n <= int'(amt) + 4) begin
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                start = poke & busy;
                if (poke) begin
                    mode   = 2'($urandom);
                    amount = CNT_W'($urandom);
                end
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        got = sb.pop_front();
        chk("op_data", 32'(data_out), 32'(got.data));
        chk("op_sticky", 32'(sticky), 32'(got.sticky));
        chk("op_latency", 32'(n - 1), 32'(got.lat));
        chk("op_busy_cycles", 32'(busy_cnt), 32'(got.lat));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_not_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int  saw;
        logic [WIDTH-1:0] held;
        clear_n = 1'b0;
        data_in = '0;
        F       = 1'b0;
        load    = 1'b0;
        start   = 1'b0;
        mode    = 2'b00;
        amount  = '0;
        m_data   = '0;
        m_sticky = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_sticky", 32'(sticky), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        clear_n = 1'b1;

        do_load(1'b1, 23'h000003);
        chk("r31_load", 32'(data_out), 32'h800003);
        do_op(2'b00, 5'd2, 1'b0);
        chk("r31_data", 32'(data_out), 32'h200000);
        chk("r31_sticky", 32'(sticky), 32'd1);

        do_load(1'b1, 23'h000003);
        do_op(2'b11, 5'd4, 1'b0);
        chk("r32_rol", 32'(data_out), 32'h000038);
        do_op(2'b01, 5'd1, 1'b0);
        chk("r32_lsl", 32'(data_out), 32'h000070);
        chk("r32_sticky", 32'(sticky), 32'd0);

        do_load(1'b1, 23'h7FFFFF);
        do_op(2'b00, 5'd30, 1'b0);
        chk("r33_data", 32'(data_out), 32'd0);
        chk("r33_sticky", 32'(sticky), 32'd1);

        do_load(1'b0, 23'h123456);
        do_op(2'b10, 5'd0, 1'b0);
        chk("r34_data", 32'(data_out), 32'h123456);

        // Load and start together: load wins, no operation follows.
        @(negedge clk);
        load    = 1'b1;
        start   = 1'b1;
        F       = 1'b1;
        data_in = 23'h0A5A5A;
        mode    = 2'b00;
        amount  = 5'd3;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        m_data   = 24'h8A5A5A;
        m_sticky = 1'b0;
        chk("r35_load", 32'(data_out), 32'h8A5A5A);
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy || done) saw++;
            @(negedge clk);
        end
        chk("r35_no_op", 32'(saw), 32'd0);
        chk("r35_hold", 32'(data_out), 32'h8A5A5A);

        do_op(2'b11, 5'd7, 1'b1);

        // Reset in the third cycle of a ten-step logical right.
        do_load(1'b0, 23'h3C3C3F);
        @(negedge clk);
        start  = 1'b1;
        mode   = 2'b00;
        amount = 5'd10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("r36_busy_before", 32'(busy), 32'd1);
        clear_n = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        chk("r36_data", 32'(data_out), 32'd0);
        chk("r36_sticky", 32'(sticky), 32'd0);
        chk("r36_busy", 32'(busy), 32'd0);
        saw = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) saw++;
            @(negedge clk);
        end
        chk("r36_no_done", 32'(saw), 32'd0);
        m_data   = '0;
        m_sticky = 1'b0;

        // Randomised operations against the model.
        for (int i = 0; i < 16; i++) begin
            do_load(1'($urandom), 23'($urandom));
            do_op(2'($urandom), CNT_W'($urandom), 1'($urandom));
            do_op(2'($urandom), CNT_W'($urandom_range(0, 6)), 1'b0);
        end

        // Idle with no requests: contents hold.
        held = m_data;
        repeat (5) @(negedge clk);
        chk("idle_hold_data", 32'(data_out), 32'(held));
        chk("idle_hold_sticky", 32'(sticky), 32'(m_sticky));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_reg_param
